muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS execute stage. It is launched by the control unit for MULT, MULTU, DIV and DIVU. It runs a radix-2 iterative shift-add or restoring-divide datapath over WIDTH cycles. While the unit is busy and the current instruction needs HI/LO, it raises a stall to freeze fetch and execute.

Parameters:
WIDTH, 32, operand width; also the iteration count.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  launch operation; sampled on rising clk
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
rd_req  input  1  current instruction is MFHI/MFLO
mthi_we  input  1  write HI from wdata
mtlo_we  input  1  write LO from wdata
wdata  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register (upper product / remainder)
lo  output  WIDTH  LO register (lower product / quotient)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when hi/lo are updated with a result
stall  output  1  combinational: busy & (rd_req | start | mthi_we | mtlo_we)

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, done=0, iteration counter=0, internal operand registers=0. Reset mid-operation aborts the operation; no partial result is written.
- FSM states: IDLE, RUN, FIX.
- IDLE + start at edge E0:
  - Latch op.
  - Latch |a| and |b|. For signed ops, take the magnitude of negative operands (two's complement); for unsigned ops, use the operands unchanged.
  - Record neg_q = sign(a)^sign(b) and neg_r = sign(a), both zero for unsigned ops.
  - Set cnt=0 and go to RUN.
- RUN: one iteration per cycle, cnt increments. Leave for FIX on the edge where cnt==WIDTH-1, giving WIDTH iterations on edges E1..E_WIDTH.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on multiplier LSB.
  - Divide: restoring. Shift {rem,quot} left; subtract divisor when rem >= divisor and set the quotient bit.
- FIX, at edge E_WIDTH+1:
  - Multiply: {hi,lo} = neg_q ? -product : product.
  - Divide: lo = neg_q ? -quot : quot; hi = neg_r ? -rem : rem. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - done=1 for exactly that one cycle; state=IDLE.
- Latency:
  - busy is high for WIDTH+1 cycles after E0.
  - Results are visible, and done is high, in the cycle after E_WIDTH+1.
  - A new start is accepted in that same cycle.
- Divide by zero (b==0, either signedness): lo=all ones, hi=a unmodified. Normal latency still applies.
- Signed overflow, DIV of most-negative by -1: lo=most-negative, hi=0 (natural wrap, no trap).
- start while busy: ignored, and stall is asserted. The CPU holds the instruction, and the start is re-sampled in the IDLE cycle.
- mthi_we/mtlo_we:
  - In IDLE, hi/lo are written from wdata at the next edge.
  - While busy, the write is ignored and stall is asserted.
  - If mthi_we/mtlo_we and start arrive in the same IDLE cycle, the MT write is applied and the later result overwrites both registers.
- rd_req while busy: stall stays high until busy falls. hi/lo are never observed mid-computation; internal accumulators are separate from hi/lo, which hold their old values until FIX.
- Arithmetic is modulo 2^WIDTH per register. All negation is two's complement.

Test Plan:
1. MULTU a=FFFFFFFF, b=FFFFFFFF, start at E0 -> busy for 33 cycles; done pulses once; hi=FFFFFFFE, lo=00000001.
2. MULT a=FFFFFFFD (-3), b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1. Then MULT 80000000*80000000 -> hi=40000000, lo=00000000.
3. DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 00000064/00000007 -> lo=0000000E, hi=00000002.
4. DIVU 00000064/0 -> lo=FFFFFFFF, hi=00000064. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
5. Busy window:
   - rd_req held from E0+1 -> stall=1 until done, then 0.
   - A second start in mid-run is ignored; results match the first operation only.
   - mthi_we during run is ignored; in IDLE it sets hi=wdata.
6. Assert rst at cycle 10 of a MULT -> hi=lo=0, busy=0, done never pulses. Then a fresh MULTU 2*3 -> lo=6, hi=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : radix-2 multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO
// Revision: 1.0
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_b_zero;
  logic [WIDTH-1:0]   r_a_raw;
  // multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum, w_div_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_acc_neg;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -a : a;
  assign w_abs_b  = w_b_neg ? -b : b;

  // shift-add: add multiplicand into the upper half on multiplier LSB, then shift right
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // restoring step: shifted remainder needs one extra bit for the compare
  assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_next = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_acc_neg = -r_acc;
  assign w_quot    = r_acc[WIDTH-1:0];
  assign w_rem     = r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == c_LAST) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_raw  <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mthi_we) r_hi <= wdata;
          if (mtlo_we) r_lo <= wdata;
          if (start) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= (b == '0);
            r_a_raw  <= a;
            r_cnt    <= '0;
            r_opnd   <= op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
        FIX: begin
          r_done <= 1'b1;
          if (!r_is_div) begin
            {r_hi, r_lo} <= r_neg_q ? w_acc_neg : r_acc;
          end else if (r_b_zero) begin
            r_lo <= '1;
            r_hi <= r_a_raw;
          end else begin
            r_lo <= r_neg_q ? -w_quot : w_quot;
            r_hi <= r_neg_r ? -w_rem : w_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign stall = busy & (rd_req | start | mthi_we | mtlo_we);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Revision: 1.0
// ============================================================================
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam logic [1:0] c_MULT = 2'b00, c_MULTU = 2'b01, c_DIV = 2'b10, c_DIVU = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0, b = '0, wdata = '0;
  logic             rd_req = 1'b0, mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [WIDTH-1:0] hi, lo;
  logic             busy, done, stall;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_sequencer #(.WIDTH(WIDTH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch one operation, then check busy length, done pulse width and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp_hi,
                        input logic [WIDTH-1:0] exp_lo);
    int busy_cnt;
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (busy) busy_cnt++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(WIDTH + 1));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] hi_before;
    bit seen;
    int done_cnt;

    #12;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    run_op("multu_max", c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  c_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("mult_min",  c_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg",   c_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb",  c_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",      c_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    run_op("divu_zero", c_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
    run_op("div_zero",  c_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",   c_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_big",  c_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

    // Busy window: rd_req stall, ignored mid-run start and MTHI, HI held mid-run.
    hi_before = hi;
    @(negedge clk);
    op = c_MULTU; a = 32'd7; b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; rd_req = 1'b1;
    seen = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      chk("busy_stall", 64'(stall), 64'd1);
      chk("busy_hi_hold", 64'(hi), 64'(hi_before));
      start = 1'b0; mthi_we = 1'b0;
      if (k == 5) begin
        rd_req = 1'b0; start = 1'b1; op = c_DIVU; a = 32'd100; b = 32'd3;
        #1 chk("start_busy_stall", 64'(stall), 64'd1);
      end
      if (k == 6) rd_req = 1'b1;
      if (k == 8) begin
        mthi_we = 1'b1; wdata = 32'hDEADBEEF;
      end
    end
    chk("win_done_seen", 64'(seen), 64'd1);
    chk("win_stall_low", 64'(stall), 64'd0);
    chk("win_hi", 64'(hi), 64'd0);
    chk("win_lo", 64'(lo), 64'd42);
    rd_req = 1'b0;
    @(negedge clk);
    chk("win_no_restart", 64'(busy), 64'd0);

    // MTHI/MTLO in IDLE
    mthi_we = 1'b1; wdata = 32'h12345678;
    @(posedge clk);
    #1 mthi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'h12345678);
    chk("mthi_lo_kept", 64'(lo), 64'd42);
    @(negedge clk);
    mtlo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 mtlo_we = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'hCAFEF00D);

    // MT write together with start: the result wins
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h55555555;
    run_op("mt_and_start", c_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    // Reset in the middle of a MULT
    @(negedge clk);
    op = c_MULT; a = 32'd5; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
    chk("mid_rst_idle", 64'(busy), 64'd0);
    run_op("after_rst", c_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
